// File: rtl/sd_cmd_serial_card.sv
// Card-side SD CMD line responder: receives 48-bit host commands, checks framing/CRC7,
// hands them to local logic, and serialises the 48-bit response after the NCR gap.
module sd_cmd_serial_card #(
  parameter int unsigned NCR_MIN  = 2,
  parameter bit          DROP_BAD = 1'b1
) (
  input  logic        SD_CLK_IN,
  input  logic        RST_IN,
  input  logic        cmd_dat_i,
  output logic        cmd_out_o,
  output logic        cmd_oe_o,
  output logic [37:0] CMD_OUT,
  output logic        CMD_VALID,
  input  logic        CMD_ACK_IN,
  output logic [7:0]  STATUS,
  input  logic [37:0] RSP_IN,
  input  logic        RSP_EN_IN,
  input  logic        RSP_VALID_IN,
  output logic        RSP_ACK_OUT
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RX       = 3'd1;
  localparam logic [2:0] S_CHK      = 3'd2;
  localparam logic [2:0] S_DELIVER  = 3'd3;
  localparam logic [2:0] S_WAIT_RSP = 3'd4;
  localparam logic [2:0] S_NCR      = 3'd5;
  localparam logic [2:0] S_TX       = 3'd6;

  localparam logic [2:0] NCR_MIN_C = 3'(NCR_MIN);

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_bits40(input logic [39:0] d);
    logic [6:0] c;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      c = crc7_step(c, d[i]);
    end
    crc7_bits40 = c;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [2:0]  ncr_q, ncr_d;
  logic [6:0]  crc_q, crc_d;
  logic [37:0] cmd_out_q, cmd_out_d;
  logic        valid_q, valid_d;
  logic [3:0]  status_q, status_d;
  logic        rsp_ack_q, rsp_ack_d;

  // Data-only registers: contents are meaningless outside the states that use them.
  logic [46:0] frame_q, frame_d;
  logic [37:0] rsp_q, rsp_d;
  logic [47:0] txsr_q, txsr_d;

  logic dir_err, crc_err, stop_err;

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    ncr_d     = (ncr_q == 3'd7) ? 3'd7 : ncr_q + 3'd1;
    crc_d     = crc_q;
    cmd_out_d = cmd_out_q;
    valid_d   = valid_q;
    status_d  = status_q;
    rsp_ack_d = 1'b0;
    frame_d   = frame_q;
    rsp_d     = rsp_q;
    txsr_d    = txsr_q;
    dir_err   = 1'b0;
    crc_err   = 1'b0;
    stop_err  = 1'b0;

    case (state_q)
      S_IDLE: begin
        crc_d = 7'h00;
        if (!cmd_dat_i) begin
          state_d  = S_RX;
          bitcnt_d = 6'd1;
        end
      end

      S_RX: begin
        frame_d  = {frame_q[45:0], cmd_dat_i};
        bitcnt_d = bitcnt_q + 6'd1;
        // bitcnt_q counts bits already taken; the start bit leaves a zero CRC unchanged
        if (bitcnt_q < 6'd40) crc_d = crc7_step(crc_q, cmd_dat_i);
        if (bitcnt_q == 6'd47) begin
          state_d = S_CHK;
          ncr_d   = 3'd0;
        end
      end

      S_CHK: begin
        dir_err  = ~frame_q[46];
        crc_err  = (frame_q[7:1] != crc_q);
        stop_err = ~frame_q[0];
        status_d[2:0] = {dir_err, stop_err, crc_err};
        if (!(dir_err || crc_err || stop_err) || !DROP_BAD) begin
          cmd_out_d   = frame_q[45:8];
          status_d[3] = 1'b0;
          valid_d     = 1'b1;
          state_d     = S_DELIVER;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DELIVER: begin
        if (CMD_ACK_IN) begin
          valid_d = 1'b0;
          state_d = S_WAIT_RSP;
        end
      end

      S_WAIT_RSP: begin
        if (RSP_VALID_IN) begin
          rsp_ack_d = 1'b1;
          rsp_d     = RSP_IN;
          state_d   = RSP_EN_IN ? S_NCR : S_IDLE;
        end
      end

      S_NCR: begin
        if (ncr_q >= NCR_MIN_C) begin
          state_d  = S_TX;
          bitcnt_d = 6'd0;
          txsr_d   = {2'b00, rsp_q, crc7_bits40({2'b00, rsp_q}), 1'b1};
        end
      end

      S_TX: begin
        txsr_d   = {txsr_q[46:0], 1'b1};
        bitcnt_d = bitcnt_q + 6'd1;
        if (bitcnt_q == 6'd47) begin
          state_d     = S_IDLE;
          status_d[3] = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SD_CLK_IN) begin
    if (!RST_IN) begin
      state_q   <= S_IDLE;
      bitcnt_q  <= 6'd0;
      ncr_q     <= 3'd0;
      crc_q     <= 7'h00;
      cmd_out_q <= 38'h0;
      valid_q   <= 1'b0;
      status_q  <= 4'h0;
      rsp_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      ncr_q     <= ncr_d;
      crc_q     <= crc_d;
      cmd_out_q <= cmd_out_d;
      valid_q   <= valid_d;
      status_q  <= status_d;
      rsp_ack_q <= rsp_ack_d;
    end
  end

  always_ff @(posedge SD_CLK_IN) begin
    frame_q <= frame_d;
    rsp_q   <= rsp_d;
    txsr_q  <= txsr_d;
  end

  // The line idles high (pull-up), so the undriven value is 1.
  assign cmd_oe_o    = (state_q == S_TX);
  assign cmd_out_o   = (state_q == S_TX) ? txsr_q[47] : 1'b1;
  assign CMD_OUT     = cmd_out_q;
  assign CMD_VALID   = valid_q;
  assign STATUS      = {4'h0, status_q};
  assign RSP_ACK_OUT = rsp_ack_q;

endmodule

// File: tb/tb_sd_cmd_serial_card.sv
// Directed bench for sd_cmd_serial_card: a DROP_BAD=1 card under test plus a DROP_BAD=0
// card that auto-acknowledges and never responds.
module tb_sd_cmd_serial_card;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cmd_dat, ack, rsp_en, rsp_valid;
  logic [37:0] rsp;
  logic        cmd_out, cmd_oe, cmd_valid, rsp_ack;
  logic [37:0] cmd_o;
  logic [7:0]  status;
  logic        nd_cmd_out, nd_cmd_oe, nd_valid, nd_rsp_ack;
  logic [37:0] nd_cmd_o;
  logic [7:0]  nd_status;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int oe_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (cmd_oe === 1'b1) oe_cnt <= oe_cnt + 1;

  sd_cmd_serial_card #(.NCR_MIN(2), .DROP_BAD(1'b1)) u_dut (
    .SD_CLK_IN(clk), .RST_IN(rst_n), .cmd_dat_i(cmd_dat),
    .cmd_out_o(cmd_out), .cmd_oe_o(cmd_oe),
    .CMD_OUT(cmd_o), .CMD_VALID(cmd_valid), .CMD_ACK_IN(ack), .STATUS(status),
    .RSP_IN(rsp), .RSP_EN_IN(rsp_en), .RSP_VALID_IN(rsp_valid), .RSP_ACK_OUT(rsp_ack)
  );

  sd_cmd_serial_card #(.NCR_MIN(2), .DROP_BAD(1'b0)) u_dut_nd (
    .SD_CLK_IN(clk), .RST_IN(rst_n), .cmd_dat_i(cmd_dat),
    .cmd_out_o(nd_cmd_out), .cmd_oe_o(nd_cmd_oe),
    .CMD_OUT(nd_cmd_o), .CMD_VALID(nd_valid), .CMD_ACK_IN(1'b1), .STATUS(nd_status),
    .RSP_IN(38'h0), .RSP_EN_IN(1'b0), .RSP_VALID_IN(1'b1), .RSP_ACK_OUT(nd_rsp_ack)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the negedge after the stop bit has been sampled.
  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      cmd_dat = f[i];
    end
    @(negedge clk);
    cmd_dat = 1'b1;
  endtask

  task automatic ack_cmd();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic respond(input logic [37:0] r, input logic en);
    rsp       = r;
    rsp_en    = en;
    rsp_valid = 1'b1;
    @(negedge clk);
    chk("rsp_ack_pulse", rsp_ack, 1'b1);
    rsp_valid = 1'b0;
  endtask

  task automatic wait_oe(output int found);
    int w;
    w = 0;
    while (cmd_oe !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    found = (cmd_oe === 1'b1) ? 1 : 0;
  endtask

  task automatic capture(input int ref_cyc, output logic [47:0] bits, output int len,
                         output int gap);
    int found;
    bits = '0;
    len  = 0;
    gap  = -1;
    wait_oe(found);
    if (found == 1) begin
      gap = cyc - ref_cyc;
      while (cmd_oe === 1'b1 && len < 60) begin
        bits = {bits[46:0], cmd_out};
        len++;
        @(negedge clk);
      end
    end
  endtask

  localparam logic [47:0] CMD0     = 48'h400000000095;
  localparam logic [47:0] CMD0_BAD = 48'h400000000097;
  localparam logic [47:0] CMD8     = 48'h48000001AA87;
  localparam logic [47:0] DIRSTOP0 = 48'h000000000000;
  localparam logic [37:0] CMD8_BODY = {6'h08, 32'h000001AA};
  localparam logic [47:0] R7_WIRE  = 48'h08000001AA13;

  initial begin
    logic [47:0] bits;
    int len, gap, stop_cyc, oe0, found, bad_hold, bad_ack;

    rst_n = 1'b0; cmd_dat = 1'b1; ack = 1'b0; rsp_en = 1'b0; rsp_valid = 1'b0; rsp = '0;
    idle(3);
    chk("rst_oe", cmd_oe, 1'b0);
    chk("rst_cmd_out", cmd_out, 1'b1);
    chk("rst_CMD_OUT", cmd_o, 38'h0);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_status", status, 8'h00);
    chk("rst_rsp_ack", rsp_ack, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // CMD0, no response requested
    oe0 = oe_cnt;
    send_frame(CMD0);
    @(negedge clk);
    chk("cmd0_valid", cmd_valid, 1'b1);
    chk("cmd0_out", cmd_o, 38'h0);
    chk("cmd0_status", status, 8'h00);
    chk("nd_cmd0_valid", nd_valid, 1'b1);
    ack_cmd();
    chk("cmd0_valid_clr", cmd_valid, 1'b0);
    respond(38'h0, 1'b0);
    @(negedge clk);
    chk("cmd0_rsp_ack_one", rsp_ack, 1'b0);
    idle(4);
    chk("cmd0_no_oe", oe_cnt - oe0, 0);

    // CMD8 with R7-style response
    idle(3);
    send_frame(CMD8);
    stop_cyc = cyc;
    @(negedge clk);
    chk("cmd8_valid", cmd_valid, 1'b1);
    chk("cmd8_out", cmd_o, CMD8_BODY);
    chk("cmd8_status", status, 8'h00);
    ack_cmd();
    respond(CMD8_BODY, 1'b1);
    capture(stop_cyc, bits, len, gap);
    chk("cmd8_rsp_len", len, 48);
    chk("cmd8_rsp_bits", bits, R7_WIRE);
    chk("cmd8_ncr_gap_ge2", (gap >= 2) ? 1 : 0, 1);
    chk("cmd8_status_sent", status, 8'h08);
    chk("cmd8_oe_off", cmd_oe, 1'b0);

    // Bad CRC: dropped here, delivered with flag on the DROP_BAD=0 card
    idle(3);
    send_frame(CMD0_BAD);
    @(negedge clk);
    chk("crc_bad_valid", cmd_valid, 1'b0);
    chk("crc_bad_status", status, 8'h09);
    chk("crc_bad_out_kept", cmd_o, CMD8_BODY);
    chk("nd_crc_bad_valid", nd_valid, 1'b1);
    chk("nd_crc_bad_status", nd_status, 8'h01);
    chk("nd_crc_bad_out", nd_cmd_o, 38'h0);

    // Dir bit 0 and stop bit 0, then a good CMD0
    idle(3);
    send_frame(DIRSTOP0);
    @(negedge clk);
    chk("dirstop_valid", cmd_valid, 1'b0);
    chk("dirstop_status", status, 8'h0E);
    chk("nd_dirstop_valid", nd_valid, 1'b1);
    chk("nd_dirstop_status", nd_status, 8'h06);
    idle(3);
    send_frame(CMD0);
    @(negedge clk);
    chk("after_err_valid", cmd_valid, 1'b1);
    chk("after_err_status", status, 8'h00);
    chk("after_err_out", cmd_o, 38'h0);
    ack_cmd();
    respond(38'h0, 1'b0);

    // Reset during response bit 20
    idle(3);
    send_frame(CMD8);
    @(negedge clk);
    chk("rst_tx_cmd8_valid", cmd_valid, 1'b1);
    ack_cmd();
    respond(CMD8_BODY, 1'b1);
    wait_oe(found);
    chk("rst_tx_started", found, 1);
    idle(20);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_tx_oe", cmd_oe, 1'b0);
    chk("rst_tx_cmd_out", cmd_out, 1'b1);
    chk("rst_tx_CMD_OUT", cmd_o, 38'h0);
    chk("rst_tx_valid", cmd_valid, 1'b0);
    chk("rst_tx_status", status, 8'h00);
    chk("rst_tx_rsp_ack", rsp_ack, 1'b0);
    rst_n = 1'b1;
    idle(3);
    send_frame(CMD8);
    stop_cyc = cyc;
    @(negedge clk);
    chk("post_rst_valid", cmd_valid, 1'b1);
    chk("post_rst_out", cmd_o, CMD8_BODY);
    ack_cmd();
    respond(CMD8_BODY, 1'b1);
    capture(stop_cyc, bits, len, gap);
    chk("post_rst_rsp_len", len, 48);
    chk("post_rst_rsp_bits", bits, R7_WIRE);
    chk("post_rst_status", status, 8'h08);

    // Ack withheld 100 cycles with a stray response request
    idle(3);
    send_frame(CMD8);
    @(negedge clk);
    chk("hold_valid", cmd_valid, 1'b1);
    bad_hold = 0;
    bad_ack  = 0;
    for (int i = 0; i < 100; i++) begin
      rsp_en    = 1'b1;
      rsp_valid = (i == 50);
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_o !== CMD8_BODY) bad_hold++;
      if (rsp_ack !== 1'b0) bad_ack++;
    end
    rsp_valid = 1'b0;
    chk("hold_stable_errs", bad_hold, 0);
    chk("hold_rsp_ignored", bad_ack, 0);
    ack       = 1'b1;
    rsp_valid = 1'b1;
    rsp_en    = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    chk("simul_valid_clr", cmd_valid, 1'b0);
    chk("simul_no_ack_yet", rsp_ack, 1'b0);
    @(negedge clk);
    chk("simul_ack_next", rsp_ack, 1'b1);
    rsp_valid = 1'b0;
    @(negedge clk);
    chk("simul_ack_one", rsp_ack, 1'b0);
    chk("simul_no_oe", cmd_oe, 1'b0);

    idle(4);
    chk("nd_oe_idle", nd_cmd_oe, 1'b0);
    chk("nd_out_idle", nd_cmd_out, 1'b1);
    chk("nd_rsp_ack_idle", nd_rsp_ack, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
